// File: rtl/spmv_mem_port_pkg.sv
// Shared field positions, entry layouts and helpers for the spmv memory-port responder.
`timescale 1ns/1ps
package spmv_mem_port_pkg;
  localparam int ADDR_W         = 48;
  localparam int DATA_W         = 64;
  localparam int TAG_W          = 3;
  localparam int RDCTL_W        = 32;
  localparam int RDCTL_WACK_BIT = 31;
  localparam int ST_CNT_W       = 16;
  localparam int REQ_ENTRY_W    = 1 + ADDR_W + DATA_W;  // 113
  localparam int RSP_ENTRY_W    = TAG_W + DATA_W;       // 67

  typedef struct packed {
    logic              st;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rsp_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/std_fifo.sv
// First-word-fall-through FIFO with occupancy count; pushes when full and pops when empty are ignored.
`timescale 1ns/1ps
module std_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/spmv_mem_port.sv
// Memory-side responder between one spmv_pe memory port and one MC port.
// Optional build macro SPMV_MEM_PORT_STATS_EN adds saturating load/store/stall counters.
`timescale 1ns/1ps
module spmv_mem_port
  import spmv_mem_port_pkg::*;
#(
  parameter int REQ_DEPTH = 16,
  parameter int REQ_SLACK = 4,
  parameter int RSP_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_mem_ld,
  input  logic                req_mem_st,
  input  logic [ADDR_W-1:0]   req_mem_addr,
  input  logic [DATA_W-1:0]   req_mem_d_or_tag,
  output logic                req_mem_stall,
  output logic                rsp_mem_push,
  output logic [TAG_W-1:0]    rsp_mem_tag,
  output logic [DATA_W-1:0]   rsp_mem_q,
  input  logic                rsp_mem_stall,
  output logic                mc_req_ld,
  output logic                mc_req_st,
  output logic [ADDR_W-1:0]   mc_req_vadr,
  output logic [DATA_W-1:0]   mc_req_wrd_rdctl,
  input  logic                mc_rd_rq_stall,
  input  logic                mc_wr_rq_stall,
  input  logic                mc_rsp_push,
  input  logic [RDCTL_W-1:0]  mc_rsp_rdctl,
  input  logic [DATA_W-1:0]   mc_rsp_data,
  output logic                mc_rsp_stall,
  output logic                idle,
  output logic                err,
  output logic [31:0]         stat_loads,
  output logic [31:0]         stat_stores,
  output logic [31:0]         stat_stall_cycles
);
  localparam int REQ_CW = $clog2(REQ_DEPTH) + 1;
  localparam int LD_W   = $clog2(RSP_DEPTH) + 1;

  // Handshakes: *_ld/*_st/*_push are one-cycle valid pulses, one transfer each;
  // *_stall is the inverse of ready and is honoured by the sender with slack.
  req_entry_t          req_in, req_head;
  rsp_entry_t          rsp_in, rsp_head;
  logic                req_wr, req_push, req_empty, req_full;
  logic [REQ_CW-1:0]   req_count;
  logic                rsp_push, rsp_pop, rsp_empty, rsp_full;
  logic [LD_W-1:0]     rsp_count;
  logic [LD_W-1:0]     ld_out;
  logic [ST_CNT_W-1:0] st_out;
  logic                can_issue, ld_issue, st_issue;
  logic                wack, ld_rsp, st_dec, err_set;
  logic                unused_rdctl;

  assign req_wr   = req_mem_ld | req_mem_st;
  assign req_push = req_wr & ~req_full;
  assign req_in   = '{st: req_mem_st, addr: req_mem_addr, data: req_mem_d_or_tag};

  std_fifo #(.WIDTH(REQ_ENTRY_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk(clk), .rst(rst), .push(req_push), .din(req_in), .pop(can_issue),
    .dout(req_head), .empty(req_empty), .full(req_full), .count(req_count)
  );

  // Head-of-line issue: a blocked head holds back everything queued behind it.
  assign can_issue = !req_empty &&
                     (req_head.st ? !mc_wr_rq_stall
                                  : (!mc_rd_rq_stall && (ld_out < LD_W'(RSP_DEPTH))));
  assign ld_issue  = can_issue && !req_head.st;
  assign st_issue  = can_issue &&  req_head.st;

  assign wack     = mc_rsp_push &  mc_rsp_rdctl[RDCTL_WACK_BIT];
  assign ld_rsp   = mc_rsp_push & ~mc_rsp_rdctl[RDCTL_WACK_BIT];
  assign rsp_push = ld_rsp & ~rsp_full;
  assign rsp_in   = '{tag: mc_rsp_rdctl[TAG_W-1:0], data: mc_rsp_data};
  assign rsp_pop  = !rsp_empty && !rsp_mem_stall;
  assign st_dec   = wack && (st_out != '0);
  assign unused_rdctl = ^mc_rsp_rdctl[RDCTL_WACK_BIT-1:TAG_W];

  std_fifo #(.WIDTH(RSP_ENTRY_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(rsp_push), .din(rsp_in), .pop(rsp_pop),
    .dout(rsp_head), .empty(rsp_empty), .full(rsp_full), .count(rsp_count)
  );

  assign err_set = (req_mem_ld & req_mem_st) | (req_wr & req_full) |
                   (wack & (st_out == '0)) | (ld_rsp & rsp_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_req_ld        <= 1'b0;
      mc_req_st        <= 1'b0;
      mc_req_vadr      <= '0;
      mc_req_wrd_rdctl <= '0;
      rsp_mem_push     <= 1'b0;
      rsp_mem_tag      <= '0;
      rsp_mem_q        <= '0;
      req_mem_stall    <= 1'b0;
      mc_rsp_stall     <= 1'b0;
      ld_out           <= '0;
      st_out           <= '0;
      err              <= 1'b0;
    end else begin
      mc_req_ld <= ld_issue;
      mc_req_st <= st_issue;
      if (can_issue) begin
        mc_req_vadr      <= req_head.addr;
        mc_req_wrd_rdctl <= req_head.st ? req_head.data
                                        : {{(DATA_W-TAG_W){1'b0}}, req_head.data[TAG_W-1:0]};
      end
      rsp_mem_push <= rsp_pop;
      if (rsp_pop) begin
        rsp_mem_tag <= rsp_head.tag;
        rsp_mem_q   <= rsp_head.data;
      end
      req_mem_stall <= (req_count >= REQ_CW'(REQ_DEPTH - REQ_SLACK));
      mc_rsp_stall  <= (rsp_count >= LD_W'(RSP_DEPTH - 2));
      // Load credits are returned only when the PE takes the data.
      case ({ld_issue, rsp_pop})
        2'b10:   ld_out <= ld_out + 1'b1;
        2'b01:   ld_out <= ld_out - 1'b1;
        default: ;
      endcase
      if (st_issue && !st_dec)      st_out <= st_out + 1'b1;
      else if (!st_issue && st_dec) st_out <= st_out - 1'b1;
      if (err_set) err <= 1'b1;
    end
  end

  assign idle = req_empty && rsp_empty && (ld_out == '0) && (st_out == '0) &&
                !mc_req_ld && !mc_req_st && !rsp_mem_push;

`ifdef SPMV_MEM_PORT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads        <= '0;
      stat_stores       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_loads        <= sat_inc32(stat_loads, ld_issue);
      stat_stores       <= sat_inc32(stat_stores, st_issue);
      stat_stall_cycles <= sat_inc32(stat_stall_cycles, req_mem_stall);
    end
  end
`else
  assign stat_loads        = '0;
  assign stat_stores       = '0;
  assign stat_stall_cycles = '0;
`endif
endmodule
